// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the board reset sequencer.
// Sequencer states, reset-cause encoding and counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    REL_SYS   = 2'd2,
    RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_LOCK = 2'd2,
    CAUSE_WDOG = 2'd3
  } cause_e;

  // One spare bit above the terminal count; counters clear at terminal so never wrap.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_btn_debounce.sv
// Reset-button synchronizer and debouncer: btn_db_o follows the synchronized
// button only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic arst_n,
  input  logic btn_i,
  output logic btn_db_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  assign btn_s = sync_q[1];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (btn_s != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = btn_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/reset_seq.sv
// Board reset generator: debounced button + PLL lock qualify a hold timer, then
// system reset releases before pixel reset. Optional watchdog: RESET_SEQ_WDOG_EN.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 8,
  parameter int WDOG_CYCLES     = 1024
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       btn_i,
  input  logic       pll_locked_i,
  input  logic       wdog_kick_i,
  output logic       rst_sys_o,
  output logic       rst_pix_o,
  output logic       rst_done_o,
  output logic [1:0] cause_o
);

  localparam int CW = cnt_width(max2(HOLD_CYCLES, STAGGER_CYCLES));
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);

  logic          btn_db;
  logic [1:0]    lock_sync_q;
  logic          lock_s;
  logic          fault;
  logic          wdog_fire;
  logic          go_wait;

  state_e        state_q, state_d;
  cause_e        cause_q, cause_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rst_sys_q, rst_sys_d;
  logic          rst_pix_q, rst_pix_d;
  logic          done_q, done_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .arst_n   (arst_n),
    .btn_i    (btn_i),
    .btn_db_o (btn_db)
  );

  assign lock_s = lock_sync_q[1];
  assign fault  = btn_db | ~lock_s;

`ifdef RESET_SEQ_WDOG_EN
  localparam int WW = cnt_width(WDOG_CYCLES);
  logic [WW-1:0] wdog_q, wdog_d;

  assign wdog_fire = (state_q == RUN) && !wdog_kick_i && (wdog_q == WW'(WDOG_CYCLES - 1));
  assign wdog_d    = ((state_q == RUN) && (state_d == RUN) && !wdog_kick_i) ? wdog_q + WW'(1) : '0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  logic unused_kick;
  assign unused_kick = wdog_kick_i;
  assign wdog_fire   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_sys_d = rst_sys_q;
    rst_pix_d = rst_pix_q;
    done_d    = done_q;
    cause_d   = cause_q;
    go_wait   = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (!fault) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (fault) begin
          go_wait = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = REL_SYS;
          rst_sys_d = 1'b0;
          cnt_d     = '0;
        end
      end
      REL_SYS: begin
        cnt_d = cnt_q + CW'(1);
        if (fault) begin
          go_wait = 1'b1;
        end else if (cnt_q == STAG_LAST) begin
          state_d   = RUN;
          rst_pix_d = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      RUN: begin
        if (fault || wdog_fire) go_wait = 1'b1;
      end
      default: go_wait = 1'b1;
    endcase

    // Re-entering WAIT_LOCK reasserts both resets and records why; button outranks lock.
    if (go_wait) begin
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      rst_sys_d = 1'b1;
      rst_pix_d = 1'b1;
      done_d    = 1'b0;
      if (btn_db)       cause_d = CAUSE_BTN;
      else if (!lock_s) cause_d = CAUSE_LOCK;
      else              cause_d = CAUSE_WDOG;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lock_sync_q <= 2'b00;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      rst_sys_q   <= 1'b1;
      rst_pix_q   <= 1'b1;
      done_q      <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_sys_q   <= rst_sys_d;
      rst_pix_q   <= rst_pix_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
    end
  end

  assign rst_sys_o  = rst_sys_q;
  assign rst_pix_o  = rst_pix_q;
  assign rst_done_o = done_q;
  assign cause_o    = cause_q;

endmodule
